// File: rtl/noc_demux_1ton_buf_if.sv
// Handshake bundle for the 1-to-N buffered NoC demux: one input channel, N output channels.
interface noc_demux_1ton_buf_if #(
  parameter int DATA_W = 16,
  parameter int N_OUT  = 4
);
  localparam int SEL_W = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1;

  logic                    enable_i;
  logic [DATA_W-1:0]       data_i;
  logic [SEL_W-1:0]        sel_i;
  logic                    valid_i;
  logic                    ready_o;
  logic [N_OUT*DATA_W-1:0] data_o;
  logic [N_OUT-1:0]        valid_o;
  logic [N_OUT-1:0]        ready_i;
  logic                    err_o;

  modport slave (
    input  enable_i, data_i, sel_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, err_o
  );

  modport master (
    output enable_i, data_i, sel_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, err_o
  );
endinterface

// File: rtl/noc_demux_1ton_buf.sv
// 1-to-N NoC demux with an independent FIFO per output; head entry is presented straight from storage.
// NOC_DEMUX_DROP_CNT_EN adds a saturating 16-bit drop counter output (drop_cnt_o).
module noc_demux_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];
  assign pop     = valid_o & ready_i;

  // Caller never pushes while full, so push and pop simply offset each other.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module noc_demux_1ton_buf #(
  parameter int DATA_W = 16,
  parameter int N_OUT  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  noc_demux_1ton_buf_if.slave  bus
`ifdef NOC_DEMUX_DROP_CNT_EN
  , output logic [15:0]        drop_cnt_o
`endif
);
  localparam int SEL_W = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1;

  logic [N_OUT-1:0]             sel_hit, full, push;
  logic [N_OUT-1:0][DATA_W-1:0] head;
  logic                         sel_ok, sel_full, ready, accept, err_q;

  // Decode by equality so an out-of-range sel never indexes past full[].
  always_comb begin
    sel_hit  = '0;
    sel_ok   = 1'b0;
    sel_full = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.sel_i == SEL_W'(k)) begin
        sel_hit[k] = 1'b1;
        sel_ok     = 1'b1;
        sel_full   = full[k];
      end
    end
  end

  // A same-cycle pop never frees space for the incoming flit.
  assign ready  = bus.enable_i & (~sel_ok | ~sel_full);
  assign accept = bus.valid_i & ready;
  assign push   = sel_hit & {N_OUT{accept}};

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    noc_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[k]),
      .data_i  (bus.data_i),
      .ready_i (bus.ready_i[k]),
      .valid_o (bus.valid_o[k]),
      .data_o  (head[k]),
      .full_o  (full[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= accept & ~sel_ok;
  end

`ifdef NOC_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      drop_cnt_q <= '0;
    else if (accept & ~sel_ok & (drop_cnt_q != 16'hFFFF))
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_cnt_o = drop_cnt_q;
`endif

  assign bus.ready_o = ready;
  assign bus.data_o  = head;
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_noc_demux_1ton_buf.sv
// Bench for noc_demux_1ton_buf: directed scenarios plus random traffic against a queue model.
module tb_noc_demux_1ton_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_demux_1ton_buf_if #(.DATA_W(16), .N_OUT(4)) ia ();
  noc_demux_1ton_buf_if #(.DATA_W(16), .N_OUT(3)) ib ();

`ifdef NOC_DEMUX_DROP_CNT_EN
  logic [15:0] drop_a, drop_b;
`endif

  noc_demux_1ton_buf #(.DATA_W(16), .N_OUT(4), .DEPTH(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ia.slave)
`ifdef NOC_DEMUX_DROP_CNT_EN
    , .drop_cnt_o(drop_a)
`endif
  );

  noc_demux_1ton_buf #(.DATA_W(16), .N_OUT(3), .DEPTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ib.slave)
`ifdef NOC_DEMUX_DROP_CNT_EN
    , .drop_cnt_o(drop_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: one FIFO queue per output channel of dut_a, capacity 2.
  logic [15:0] mq [4][$];

  function automatic bit model_ready(bit en, int sel);
    return en && (sel >= 4 || mq[sel].size() < 2);
  endfunction

  task automatic drive(bit en, bit v, logic [1:0] sel, logic [15:0] d, logic [3:0] rdy);
    ia.enable_i = en;
    ia.valid_i  = v;
    ia.sel_i    = sel;
    ia.data_i   = d;
    ia.ready_i  = rdy;
  endtask

  // Apply the clock edge to the model using the currently driven inputs, then move to the next negedge.
  task automatic advance();
    bit acc;
    acc = ia.valid_i && model_ready(ia.enable_i, int'(ia.sel_i));
    for (int k = 0; k < 4; k++)
      if (mq[k].size() > 0 && ia.ready_i[k]) void'(mq[k].pop_front());
    if (acc) mq[ia.sel_i].push_back(ia.data_i);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) mq[k].delete();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 16'h0, 4'h0);
    ib.enable_i = 1'b0; ib.valid_i = 1'b0; ib.sel_i = '0; ib.data_i = '0; ib.ready_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ia.valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got=%b exp=0000", ia.valid_o); end
    n_checks++;
    if (ia.data_o !== 64'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", ia.data_o); end
    n_checks++;
    if (ia.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", ia.err_o); end
    rst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  task automatic test_single();
    drive(1, 1, 2, 16'hA5A5, 4'hF);
    #1;
    n_checks++;
    if (ia.ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", ia.ready_o); end
    advance();
    drive(1, 0, 0, 16'h0, 4'hF);
    n_checks++;
    if (ia.valid_o !== 4'b0100) begin n_fail++; $display("FAIL single_valid got=%b exp=0100", ia.valid_o); end
    n_checks++;
    if (ia.data_o[47:32] !== 16'hA5A5) begin n_fail++; $display("FAIL single_data got=%h exp=a5a5", ia.data_o[47:32]); end
    advance();
    n_checks++;
    if (ia.valid_o !== 4'b0000) begin n_fail++; $display("FAIL single_once got=%b exp=0000", ia.valid_o); end
  endtask

  task automatic test_backpressure();
    drive(1, 1, 0, 16'h0001, 4'b1110); advance();
    drive(1, 1, 0, 16'h0002, 4'b1110); advance();
    drive(1, 1, 0, 16'h0003, 4'b1110);
    #1;
    n_checks++;
    if (ia.ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", ia.ready_o); end
    advance();
    drive(1, 1, 3, 16'h0333, 4'b1110);
    #1;
    n_checks++;
    if (ia.ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready got=%b exp=1", ia.ready_o); end
    advance();
    drive(1, 0, 0, 16'h0, 4'hF);
    n_checks++;
    if (ia.valid_o !== 4'b1001) begin n_fail++; $display("FAIL bp_valid got=%b exp=1001", ia.valid_o); end
    n_checks++;
    if (ia.data_o[63:48] !== 16'h0333) begin n_fail++; $display("FAIL bp_ch3_data got=%h exp=0333", ia.data_o[63:48]); end
    n_checks++;
    if (ia.data_o[15:0] !== 16'h0001) begin n_fail++; $display("FAIL bp_first got=%h exp=0001", ia.data_o[15:0]); end
    advance();
    n_checks++;
    if (ia.valid_o[0] !== 1'b1 || ia.data_o[15:0] !== 16'h0002) begin
      n_fail++; $display("FAIL bp_second got=%b/%h exp=1/0002", ia.valid_o[0], ia.data_o[15:0]);
    end
    advance();
    n_checks++;
    if (ia.valid_o !== 4'b0000) begin n_fail++; $display("FAIL bp_drained got=%b exp=0000", ia.valid_o); end
  endtask

  task automatic test_mid_reset();
    drive(1, 1, 1, 16'hB001, 4'b1101); advance();
    drive(1, 1, 1, 16'hB002, 4'b1101); advance();
    drive(1, 0, 0, 16'h0, 4'b1101);
    n_checks++;
    if (ia.valid_o !== 4'b0010) begin n_fail++; $display("FAIL mrst_queued got=%b exp=0010", ia.valid_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ia.valid_o !== 4'b0000 || ia.err_o !== 1'b0) begin
      n_fail++; $display("FAIL mrst_async got=%b/%b exp=0000/0", ia.valid_o, ia.err_o);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 16'h0, 4'hF);
    advance();
    n_checks++;
    if (ia.valid_o !== 4'b0000) begin n_fail++; $display("FAIL mrst_lost got=%b exp=0000", ia.valid_o); end
  endtask

  task automatic test_invalid_sel();
    ib.enable_i = 1'b1; ib.valid_i = 1'b1; ib.sel_i = 2'd3; ib.data_i = 16'hDEAD; ib.ready_i = 3'b111;
    #1;
    n_checks++;
    if (ib.ready_o !== 1'b1) begin n_fail++; $display("FAIL badsel_ready got=%b exp=1", ib.ready_o); end
    @(negedge clk);
    ib.valid_i = 1'b0;
    n_checks++;
    if (ib.err_o !== 1'b1) begin n_fail++; $display("FAIL badsel_err got=%b exp=1", ib.err_o); end
    n_checks++;
    if (ib.valid_o !== 3'b000) begin n_fail++; $display("FAIL badsel_valid got=%b exp=000", ib.valid_o); end
`ifdef NOC_DEMUX_DROP_CNT_EN
    n_checks++;
    if (drop_b !== 16'd1) begin n_fail++; $display("FAIL badsel_cnt got=%0d exp=1", drop_b); end
`endif
    @(negedge clk);
    n_checks++;
    if (ib.err_o !== 1'b0) begin n_fail++; $display("FAIL badsel_pulse got=%b exp=0", ib.err_o); end
  endtask

  task automatic test_enable();
    drive(1, 1, 2, 16'h0C2C, 4'b1011); advance();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 2, 16'h0C2D, 4'hF);
      #1;
      n_checks++;
      if (ia.ready_o !== 1'b0) begin n_fail++; $display("FAIL en_ready cyc=%0d got=%b exp=0", i, ia.ready_o); end
      n_checks++;
      if (ia.valid_o[2] !== (i == 0)) begin n_fail++; $display("FAIL en_drain cyc=%0d got=%b exp=%b", i, ia.valid_o[2], i == 0); end
      if (i == 0) begin
        n_checks++;
        if (ia.data_o[47:32] !== 16'h0C2C) begin n_fail++; $display("FAIL en_data got=%h exp=0c2c", ia.data_o[47:32]); end
      end
      advance();
    end
  endtask

  task automatic test_full_pop();
    drive(1, 1, 1, 16'h0011, 4'b1101); advance();
    drive(1, 1, 1, 16'h0022, 4'b1101); advance();
    drive(1, 1, 1, 16'h0033, 4'b1111);
    #1;
    n_checks++;
    if (ia.ready_o !== 1'b0) begin n_fail++; $display("FAIL fpop_refuse got=%b exp=0", ia.ready_o); end
    advance();
    drive(1, 1, 1, 16'h0033, 4'b1101);
    #1;
    n_checks++;
    if (ia.ready_o !== 1'b1) begin n_fail++; $display("FAIL fpop_accept got=%b exp=1", ia.ready_o); end
    n_checks++;
    if (ia.data_o[31:16] !== 16'h0022) begin n_fail++; $display("FAIL fpop_head got=%h exp=0022", ia.data_o[31:16]); end
    advance();
    drive(1, 0, 0, 16'h0, 4'hF);
    n_checks++;
    if (ia.data_o[31:16] !== 16'h0022) begin n_fail++; $display("FAIL fpop_order1 got=%h exp=0022", ia.data_o[31:16]); end
    advance();
    n_checks++;
    if (ia.valid_o[1] !== 1'b1 || ia.data_o[31:16] !== 16'h0033) begin
      n_fail++; $display("FAIL fpop_order2 got=%b/%h exp=1/0033", ia.valid_o[1], ia.data_o[31:16]);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            16'($urandom), 4'($urandom));
      #1;
      n_checks++;
      if (ia.ready_o !== model_ready(ia.enable_i, int'(ia.sel_i))) begin
        n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, ia.ready_o, model_ready(ia.enable_i, int'(ia.sel_i)));
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (ia.valid_o[k] !== (mq[k].size() > 0)) begin
          n_fail++; $display("FAIL rnd_valid cyc=%0d ch=%0d got=%b exp=%b", c, k, ia.valid_o[k], mq[k].size() > 0);
        end else if (mq[k].size() > 0) begin
          n_checks++;
          if (ia.data_o[k*16 +: 16] !== mq[k][0]) begin
            n_fail++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", c, k, ia.data_o[k*16 +: 16], mq[k][0]);
          end
        end
      end
      n_checks++;
      if (ia.err_o !== 1'b0) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=0", c, ia.err_o); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_mid_reset();
    test_invalid_sel();
    test_enable();
    test_full_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
